// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the load/store path: funct3 encodings, LSU states and
// the access legality rule used at request accept.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, RD_WAIT, WR} lsu_state_t;

  // Unsigned sizes exist only for loads; halves need an even address, words an aligned one.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] offset);
    logic err;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = offset[0];
      F3_W:    err = |offset;
      F3_BU:   err = we;
      F3_HU:   err = we | offset[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: access check, little-endian load extraction and sub-word
// store merge into the old RAM word.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        chk_we,
  input  logic [2:0]  chk_funct3,
  input  logic [1:0]  chk_offset,
  output logic        err,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] new_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] mask;
  logic [31:0] ins;

  always_comb begin
    err    = access_err(chk_we, chk_funct3, chk_offset);
    lane_b = old_word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? old_word[31:16] : old_word[15:0];

    case (funct3)
      F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
      F3_BU:   rdata = {24'h0, lane_b};
      F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
      F3_HU:   rdata = {16'h0, lane_h};
      default: rdata = old_word;
    endcase

    case (funct3)
      F3_B: begin
        mask = 32'h0000_00ff << {offset, 3'b000};
        ins  = {24'h0, wdata[7:0]} << {offset, 3'b000};
      end
      F3_H: begin
        mask = 32'h0000_ffff << {offset[1], 4'b0000};
        ins  = {16'h0, wdata[15:0]} << {offset[1], 4'b0000};
      end
      default: begin
        mask = 32'hffff_ffff;
        ins  = wdata;
      end
    endcase
    new_word = (old_word & ~mask) | ins;
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit driving a synchronous word RAM; sub-word stores are done as
// read-modify-write because the RAM only writes whole words.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clock,
  input  logic              nreset,
  load_store_unit_if.slave  bus,
  output logic              ramR,
  output logic              ramW,
  output logic [31:0]       addr,
  output logic [DWIDTH-1:0] dataW,
  input  logic [DWIDTH-1:0] dataR
);

  lsu_state_t  state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        ram_r_q, ram_w_q;
  logic [31:0] addr_q, data_w_q;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        req_err;
  logic [31:0] ld_data, merged;

  lsu_align u_align (
    .chk_we     (bus.req_we),
    .chk_funct3 (bus.req_funct3),
    .chk_offset (bus.req_addr[1:0]),
    .err        (req_err),
    .funct3     (f3_q),
    .offset     (off_q),
    .old_word   (dataR),
    .wdata      (wdata_q),
    .rdata      (ld_data),
    .new_word   (merged)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      ram_r_q      <= 1'b0;
      ram_w_q      <= 1'b0;
      addr_q       <= '0;
      data_w_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      // Strobes and response are single-cycle pulses; addr/dataW hold.
      ram_r_q      <= 1'b0;
      ram_w_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            off_q   <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              addr_q <= {2'b00, bus.req_addr[31:2]};
              if (bus.req_we && bus.req_funct3 == F3_W) begin
                ram_w_q  <= 1'b1;
                data_w_q <= bus.req_wdata;
                state_q  <= WR;
              end else begin
                ram_r_q <= 1'b1;
                state_q <= RD;
              end
            end
          end
        end
        RD: state_q <= RD_WAIT;
        RD_WAIT: begin
          if (we_q) begin
            data_w_q <= merged;
            ram_w_q  <= 1'b1;
            state_q  <= WR;
          end else begin
            resp_rdata_q <= ld_data;
            resp_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign ramR           = ram_r_q;
  assign ramW           = ram_w_q;
  assign addr           = addr_q;
  assign dataW          = data_w_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word RAM model plus a byte-level reference of memory
// contents and access rules; directed plan cases followed by random traffic.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic        ramR, ramW;
  logic [31:0] addr, dataW, dataR;

  load_store_unit_if bus ();

  load_store_unit #(.DWIDTH(32)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus),
    .ramR   (ramR),
    .ramW   (ramW),
    .addr   (addr),
    .dataW  (dataW),
    .dataR  (dataR)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  // Synchronous RAM: read data appears the cycle after ramR is sampled.
  always @(posedge clock) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (ramW) mem[addr[5:0]] <= dataW;
    if (ramR) dataR <= mem[addr[5:0]];
  end

  always @(negedge clock) if (ramR && ramW) overlap++;

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << (f3 & 3'd3);
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    return !legal || (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [2:0] f3);
    longint v;
    int     off, sz;
    off = int'(a % 4);
    sz  = acc_size(f3);
    v   = 0;
    for (int i = 0; i < sz; i++) v += ((longint'(word) >> (8 * (off + i))) & 255) << (8 * i);
    if (f3 < 3'd4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [31:0] a, input logic [2:0] f3);
    logic [7:0]  b [4];
    logic [31:0] r;
    int          off;
    off = int'(a % 4);
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    for (int i = 0; i < acc_size(f3); i++) b[off + i] = wd[8*i +: 8];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clock);
    bd_we = 1'b1; bd_idx = idx[5:0]; bd_data = val;
    @(negedge clock);
    bd_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string name, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rd, exp_word, seen_dw;
    int          exp_lat, exp_nr, exp_nw, idx, lat, nr, nw, w;
    bit          addr_bad, rdy_bad;
    idx = int'(a[5:2]);
    exp_err = ref_err(we, f3, a);
    exp_word = ref_mem[idx];
    exp_rd = '0;
    if (exp_err) begin
      exp_lat = 1; exp_nr = 0; exp_nw = 0;
    end else if (we) begin
      exp_word = ref_merge(ref_mem[idx], wd, a, f3);
      exp_lat = (f3 == F3_W) ? 2 : 4;
      exp_nr  = (f3 == F3_W) ? 0 : 1;
      exp_nw  = 1;
    end else begin
      exp_rd = ref_load(ref_mem[idx], a, f3);
      exp_lat = 3; exp_nr = 1; exp_nw = 0;
    end
    ref_mem[idx] = exp_word;
    got = '0;

    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (w >= 20) begin
      total++; bad++;
      $display("FAIL %s accept: req_ready stayed %b, required 1", name, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    lat = 1; nr = 0; nw = 0; addr_bad = 0; rdy_bad = 0; seen_dw = '0;
    while (lat <= 8) begin
      if (ramR) begin
        nr++;
        if (addr !== {2'b00, a[31:2]}) addr_bad = 1;
      end
      if (ramW) begin
        nw++;
        seen_dw = dataW;
        if (addr !== {2'b00, a[31:2]}) addr_bad = 1;
      end
      if (bus.resp_valid) break;
      if (bus.req_ready) rdy_bad = 1;
      @(negedge clock);
      lat++;
    end
    got = bus.resp_rdata;

    total++; if (lat != exp_lat) begin bad++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat); end
    total++; if (bus.resp_err !== exp_err) begin bad++;
      $display("FAIL %s resp_err: got %b required %b", name, bus.resp_err, exp_err); end
    total++; if (bus.resp_rdata !== exp_rd) begin bad++;
      $display("FAIL %s resp_rdata: got %h required %h", name, bus.resp_rdata, exp_rd); end
    total++; if (nr != exp_nr) begin bad++;
      $display("FAIL %s ramR pulses: got %0d required %0d", name, nr, exp_nr); end
    total++; if (nw != exp_nw) begin bad++;
      $display("FAIL %s ramW pulses: got %0d required %0d", name, nw, exp_nw); end
    total++; if (addr_bad || rdy_bad) begin bad++;
      $display("FAIL %s addr/ready while busy: addr_bad=%0d rdy_bad=%0d required 0/0",
               name, addr_bad, rdy_bad); end
    total++; if (mem[idx] !== exp_word) begin bad++;
      $display("FAIL %s mem[%0d]: got %h required %h", name, idx, mem[idx], exp_word); end
    if (nw > 0) begin
      total++; if (seen_dw !== exp_word) begin bad++;
        $display("FAIL %s dataW: got %h required %h", name, seen_dw, exp_word); end
    end
    @(negedge clock);
    total++; if (bus.resp_valid !== 1'b0) begin bad++;
      $display("FAIL %s pulse width: resp_valid got %b required 0", name, bus.resp_valid); end
  endtask

  task automatic test_reset();
    #1 nreset = 1'b0;
    #3;
    total++;
    if ({ramR, ramW, addr, dataW, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== '0 ||
        bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset outputs: ramR=%b ramW=%b addr=%h dataW=%h rv=%b re=%b rd=%h rdy=%b",
               ramR, ramW, addr, dataW, bus.resp_valid, bus.resp_err, bus.resp_rdata,
               bus.req_ready);
    end
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b1;
  endtask

  task automatic test_load_word();
    logic [31:0] got;
    preload(4, 32'hDEADBEEF);
    do_req(1'b0, F3_W, 32'h10, 32'h0, "lw", got);
    total++; if (got !== 32'hDEADBEEF) begin bad++;
      $display("FAIL lw value: got %h required deadbeef", got); end
  endtask

  task automatic test_subword_loads();
    logic [31:0] got;
    do_req(1'b0, F3_B, 32'h13, 32'h0, "lb", got);
    total++; if (got !== 32'hFFFFFFDE) begin bad++;
      $display("FAIL lb value: got %h required ffffffde", got); end
    do_req(1'b0, F3_BU, 32'h13, 32'h0, "lbu", got);
    total++; if (got !== 32'h000000DE) begin bad++;
      $display("FAIL lbu value: got %h required 000000de", got); end
    do_req(1'b0, F3_H, 32'h12, 32'h0, "lh", got);
    total++; if (got !== 32'hFFFFDEAD) begin bad++;
      $display("FAIL lh value: got %h required ffffdead", got); end
    do_req(1'b0, F3_HU, 32'h10, 32'h0, "lhu", got);
    total++; if (got !== 32'h0000BEEF) begin bad++;
      $display("FAIL lhu value: got %h required 0000beef", got); end
  endtask

  task automatic test_subword_stores();
    logic [31:0] got;
    do_req(1'b1, F3_B, 32'h11, 32'h0000_0055, "sb", got);
    total++; if (mem[4] !== 32'hDEAD55EF) begin bad++;
      $display("FAIL sb word: got %h required dead55ef", mem[4]); end
    preload(4, 32'hDEADBEEF);
    do_req(1'b1, F3_H, 32'h12, 32'h0000_1234, "sh", got);
    total++; if (mem[4] !== 32'h1234BEEF) begin bad++;
      $display("FAIL sh word: got %h required 1234beef", mem[4]); end
  endtask

  task automatic test_errors();
    logic [31:0] got;
    do_req(1'b0, F3_W, 32'h11, 32'h0, "lw_misaligned", got);
    do_req(1'b1, F3_H, 32'h13, 32'hFFFF_FFFF, "sh_misaligned", got);
    do_req(1'b1, F3_BU, 32'h10, 32'hFFFF_FFFF, "store_f3_100", got);
  endtask

  task automatic test_back_to_back();
    int n, w, rdy_bad;
    preload(8, 32'h0);
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hA5A5A5A5;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    @(posedge clock);
    @(negedge clock);
    bus.req_we = 1'b0; bus.req_funct3 = F3_W; bus.req_wdata = 32'h0;
    n = 1; rdy_bad = 0;
    while (!bus.resp_valid && n < 8) begin
      if (bus.req_ready) rdy_bad++;
      @(negedge clock);
      n++;
    end
    total++; if (n != 2 || bus.req_ready !== 1'b1) begin bad++;
      $display("FAIL b2b store resp: latency %0d ready %b, required 2 and 1", n, bus.req_ready);
    end
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.resp_valid && n < 8) begin
      if (bus.req_ready) rdy_bad++;
      @(negedge clock);
      n++;
    end
    total++; if (n != 3) begin bad++;
      $display("FAIL b2b load latency: got %0d required 3", n); end
    total++; if (bus.resp_rdata !== 32'hA5A5A5A5 || bus.resp_err !== 1'b0) begin bad++;
      $display("FAIL b2b load data: got %h err %b required a5a5a5a5 err 0",
               bus.resp_rdata, bus.resp_err); end
    total++; if (rdy_bad != 0) begin bad++;
      $display("FAIL b2b ready while busy: got %0d high cycles required 0", rdy_bad); end
    ref_mem[8] = 32'hA5A5A5A5;
  endtask

  task automatic test_reset_rmw();
    int w;
    preload(5, 32'h11223344);
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'h15; bus.req_wdata = 32'h0000_00AA;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    total++; if (ramR !== 1'b1) begin bad++;
      $display("FAIL rmw read strobe: got %b required 1", ramR); end
    @(negedge clock);
    #1 nreset = 1'b0;
    #1;
    total++;
    if ({ramR, ramW, addr, dataW, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== '0) begin
      bad++;
      $display("FAIL reset mid rmw outputs: ramR=%b ramW=%b addr=%h dataW=%h rv=%b rd=%h",
               ramR, ramW, addr, dataW, bus.resp_valid, bus.resp_rdata);
    end
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b1;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++;
      $display("FAIL ready after reset: got %b required 1", bus.req_ready); end
    @(negedge clock);
    @(negedge clock);
    total++; if (mem[5] !== 32'h11223344) begin bad++;
      $display("FAIL mem after aborted rmw: got %h required 11223344", mem[5]); end
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)),
             $urandom, "rand", got);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_load_word();
    test_subword_loads();
    test_subword_stores();
    test_errors();
    test_back_to_back();
    test_reset_rmw();
    test_random();
    total++; if (overlap != 0) begin bad++;
      $display("FAIL strobe overlap: ramR&ramW cycles got %0d required 0", overlap); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
